// File: rtl/pipe_addsub.sv
// Pipelined carry-select adder/subtractor: STAGES segments, each followed by one register stage.
// Define PIPE_ADDSUB_SAT_EN to saturate Sum on signed overflow in the final stage.
module pipe_addsub #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             Ovf
);

   localparam int SEG  = WIDTH / STAGES;
   localparam int LAST = STAGES - 1;

   logic              adv;
   logic [STAGES-1:0] valid_reg, valid_next;
   logic [STAGES-1:0] carry_reg, carry_next;
   logic [WIDTH-1:0]  a_reg   [STAGES];
   logic [WIDTH-1:0]  b_reg   [STAGES];
   logic [WIDTH-1:0]  sum_reg [STAGES];
   logic [WIDTH-1:0]  a_next  [STAGES];
   logic [WIDTH-1:0]  b_next  [STAGES];
   logic [WIDTH-1:0]  sum_next[STAGES];
   logic              ovf_reg, ovf_next;

   // The whole pipeline moves as one; a stall only ever originates at the output.
   assign adv      = out_ready || !out_valid;
   assign in_ready = adv;

   always_comb begin
      logic [WIDTH-1:0] a_cur;
      logic [WIDTH-1:0] b_cur;
      logic [WIDTH-1:0] s_cur;
      logic             c_cur;
      logic             v_cur;
      logic [SEG:0]     seg_sum0;
      logic [SEG:0]     seg_sum1;
      logic [SEG:0]     seg_sel;

      valid_next = '0;
      carry_next = '0;
      ovf_next   = 1'b0;
      a_cur      = A;
      b_cur      = sub ? ~B : B;
      c_cur      = sub ? ~Cin : Cin;
      v_cur      = in_valid;
      s_cur      = '0;
      seg_sum0   = '0;
      seg_sum1   = '0;
      seg_sel    = '0;

      // Stage k adds its own segment; its carry-in is the carry registered by stage k-1.
      for (int k = 0; k < STAGES; k++) begin
         seg_sum0 = {1'b0, a_cur[k*SEG +: SEG]} + {1'b0, b_cur[k*SEG +: SEG]};
         seg_sum1 = {1'b0, a_cur[k*SEG +: SEG]} + {1'b0, b_cur[k*SEG +: SEG]} + (SEG+1)'(1);
         seg_sel  = c_cur ? seg_sum1 : seg_sum0;
         s_cur[k*SEG +: SEG] = seg_sel[SEG-1:0];

         a_next[k]     = a_cur;
         b_next[k]     = b_cur;
         sum_next[k]   = s_cur;
         carry_next[k] = seg_sel[SEG];
         valid_next[k] = v_cur;

         a_cur = a_reg[k];
         b_cur = b_reg[k];
         s_cur = sum_reg[k];
         c_cur = carry_reg[k];
         v_cur = valid_reg[k];
      end

      ovf_next = (a_next[LAST][WIDTH-1] == b_next[LAST][WIDTH-1]) &&
                 (sum_next[LAST][WIDTH-1] != a_next[LAST][WIDTH-1]);
`ifdef PIPE_ADDSUB_SAT_EN
      // Clamp toward the sign of A; Cout and Ovf keep reporting the raw add.
      if (ovf_next) begin
         sum_next[LAST] = a_next[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                : {1'b0, {(WIDTH-1){1'b1}}};
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_reg <= '0;
         carry_reg <= '0;
         ovf_reg   <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            a_reg[k]   <= '0;
            b_reg[k]   <= '0;
            sum_reg[k] <= '0;
         end
      end else if (adv) begin
         valid_reg <= valid_next;
         carry_reg <= carry_next;
         ovf_reg   <= ovf_next;
         for (int k = 0; k < STAGES; k++) begin
            a_reg[k]   <= a_next[k];
            b_reg[k]   <= b_next[k];
            sum_reg[k] <= sum_next[k];
         end
      end
   end

   assign out_valid = valid_reg[LAST];
   assign Sum       = sum_reg[LAST];
   assign Cout      = carry_reg[LAST];
   assign Ovf       = ovf_reg;

endmodule

// File: tb/tb_pipe_addsub.sv
// Scoreboard bench for pipe_addsub: 32/4 directed + random instance, 16/2 random instance.
// Honours PIPE_ADDSUB_SAT_EN in its reference model.
module tb_pipe_addsub;

   localparam int W1 = 32;
   localparam int S1 = 4;
   localparam int W2 = 16;
   localparam int S2 = 2;

   typedef struct packed {
      logic [63:0] sum;
      logic        cout;
      logic        ovf;
   } exp_t;

`ifdef PIPE_ADDSUB_SAT_EN
   localparam logic [63:0] E033_SUM = 64'h7FFF_FFFF;
   localparam logic [63:0] E034_SUM = 64'h8000_0000;
`else
   localparam logic [63:0] E033_SUM = 64'h8000_0000;
   localparam logic [63:0] E034_SUM = 64'h7FFF_FFFF;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          iv1, ir1, ov1, or1, cin1, sub1, cout1, ovf1;
   logic [W1-1:0] a1, b1, sum1;
   logic          iv2, ir2, ov2, or2, cin2, sub2, cout2, ovf2;
   logic [W2-1:0] a2, b2, sum2;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   acc_cyc = 0;
   exp_t q1[$];
   exp_t q2[$];
   int   pop_cyc[$];
   exp_t e1, e2;

   pipe_addsub #(.WIDTH(W1), .STAGES(S1)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .A(a1), .B(b1),
      .Cin(cin1), .sub(sub1), .out_valid(ov1), .out_ready(or1), .Sum(sum1),
      .Cout(cout1), .Ovf(ovf1)
   );

   pipe_addsub #(.WIDTH(W2), .STAGES(S2)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .A(a2), .B(b2),
      .Cin(cin2), .sub(sub2), .out_valid(ov2), .out_ready(or2), .Sum(sum2),
      .Cout(cout2), .Ovf(ovf2)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: unsigned sum for Sum/Cout, signed range test for Ovf.
   function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input logic cin, input logic sub);
      exp_t        e;
      logic [63:0] mask, bp, tot;
      longint      sa, sb, sr, lim;
      mask   = (64'd1 << w) - 64'd1;
      bp     = sub ? (~b & mask) : (b & mask);
      tot    = (a & mask) + bp + {63'd0, sub ^ cin};
      e.sum  = tot & mask;
      e.cout = tot[w];
      lim    = longint'(1) << (w - 1);
      sa     = longint'(a & mask);
      if (a[w-1]) sa = sa - (lim * 2);
      sb     = longint'(bp);
      if (bp[w-1]) sb = sb - (lim * 2);
      sr     = sa + sb + ((sub ^ cin) ? longint'(1) : longint'(0));
      e.ovf  = (sr >= lim) || (sr < -lim);
`ifdef PIPE_ADDSUB_SAT_EN
      if (e.ovf) e.sum = a[w-1] ? 64'(lim) : 64'(lim - 1);
`endif
      return e;
   endfunction

   function automatic exp_t mk(input logic [63:0] s, input logic c, input logic o);
      exp_t e;
      e.sum  = s;
      e.cout = c;
      e.ovf  = o;
      return e;
   endfunction

   function automatic logic [63:0] rnd(input int w);
      logic [63:0] v;
      logic [63:0] mask;
      mask = (64'd1 << w) - 64'd1;
      case ($urandom_range(0, 7))
         0:       v = 64'd0;
         1:       v = '1;
         2:       v = (64'd1 << (w - 1)) - 64'd1;
         3:       v = 64'd1 << (w - 1);
         default: v = {$urandom, $urandom};
      endcase
      return v & mask;
   endfunction

   task automatic check(input string name, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   function automatic longint lat();
      return (pop_cyc.size() > 0) ? longint'(pop_cyc[0] - acc_cyc) : -1;
   endfunction

   // Monitors: compare every presented result against the queue head; pop on handshake.
   always @(negedge clk) begin
      if (ov1) begin
         total++;
         if (q1.size() == 0) begin
            bad++;
            $display("FAIL mon32 unexpected result Sum=%0h Cout=%0b Ovf=%0b", sum1, cout1, ovf1);
         end else begin
            e1 = q1[0];
            if (sum1 !== e1.sum[W1-1:0] || cout1 !== e1.cout || ovf1 !== e1.ovf) begin
               bad++;
               $display("FAIL mon32 got Sum=%0h Cout=%0b Ovf=%0b exp Sum=%0h Cout=%0b Ovf=%0b",
                        sum1, cout1, ovf1, e1.sum[W1-1:0], e1.cout, e1.ovf);
            end
            if (or1) begin
               $display("txn32 cyc=%0d Sum=%0h Cout=%0b Ovf=%0b", cyc, sum1, cout1, ovf1);
               void'(q1.pop_front());
               pop_cyc.push_back(cyc);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (ov2) begin
         total++;
         if (q2.size() == 0) begin
            bad++;
            $display("FAIL mon16 unexpected result Sum=%0h Cout=%0b Ovf=%0b", sum2, cout2, ovf2);
         end else begin
            e2 = q2[0];
            if (sum2 !== e2.sum[W2-1:0] || cout2 !== e2.cout || ovf2 !== e2.ovf) begin
               bad++;
               $display("FAIL mon16 got Sum=%0h Cout=%0b Ovf=%0b exp Sum=%0h Cout=%0b Ovf=%0b",
                        sum2, cout2, ovf2, e2.sum[W2-1:0], e2.cout, e2.ovf);
            end
            if (or2) begin
               $display("txn16 cyc=%0d Sum=%0h Cout=%0b Ovf=%0b", cyc, sum2, cout2, ovf2);
               void'(q2.pop_front());
            end
         end
      end
   end

   task automatic issue1(input logic [31:0] a, input logic [31:0] b, input logic cin,
                         input logic sub, input exp_t e);
      int n;
      bit done;
      n    = 0;
      done = 0;
      iv1  = 1'b1;
      a1   = a;
      b1   = b;
      cin1 = cin;
      sub1 = sub;
      while (!done) begin
         @(negedge clk);
         if (ir1) begin
            q1.push_back(e);
            acc_cyc = cyc;
            done    = 1;
         end
         @(posedge clk);
         #1;
         n++;
         if (!done && n > 100) begin
            total++;
            bad++;
            $display("FAIL issue32 timeout in_ready=%0b required=1", ir1);
            done = 1;
         end
      end
      iv1 = 1'b0;
   endtask

   task automatic drain1();
      int n;
      n   = 0;
      or1 = 1'b1;
      while (q1.size() != 0 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain32", longint'(q1.size()), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] ta, tb;
      int sent, n, n_ov, acc0;

      iv1 = 0; or1 = 1; a1 = '0; b1 = '0; cin1 = 0; sub1 = 0;
      iv2 = 0; or2 = 1; a2 = '0; b2 = '0; cin2 = 0; sub2 = 0;

      @(posedge clk);
      #1;
      check("rst_out_valid", longint'(ov1), 0);
      check("rst_sum", longint'(sum1), 0);
      check("rst_cout", longint'(cout1), 0);
      check("rst_ovf", longint'(ovf1), 0);
      check("rst_in_ready", longint'(ir1), 1);
      check("rst_in_ready16", longint'(ir2), 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Signed overflow corners and subtraction
      pop_cyc.delete();
      issue1(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, mk(E033_SUM, 1'b0, 1'b1));
      drain1();
      check("lat_first", lat(), S1);
      issue1(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, mk(E034_SUM, 1'b1, 1'b1));
      issue1(32'd12, 32'd8, 1'b1, 1'b1, mk(64'd3, 1'b1, 1'b0));
      issue1(32'd5, 32'd7, 1'b0, 1'b1, mk(64'hFFFF_FFFE, 1'b0, 1'b0));
      drain1();

      // Back-to-back stream, full throughput
      pop_cyc.delete();
      acc0 = 0;
      for (int i = 0; i < 8; i++) begin
         issue1(32'(i), 32'(i), 1'b0, 1'b0, mk(64'(2 * i), 1'b0, 1'b0));
         if (i == 0) acc0 = acc_cyc;
      end
      drain1();
      check("stream_count", longint'(pop_cyc.size()), 8);
      check("stream_span", (pop_cyc.size() == 8) ? longint'(pop_cyc[7] - pop_cyc[0]) : -1, 7);
      check("stream_latency", (pop_cyc.size() > 0) ? longint'(pop_cyc[0] - acc0) : -1, S1);

      // Same stream with out_ready low on cycles 6..9
      sent = 0;
      for (int c = 0; c < 60 && (sent < 8 || q1.size() > 0); c++) begin
         or1  = !(c >= 6 && c <= 9);
         iv1  = (sent < 8);
         a1   = 32'(sent);
         b1   = 32'(sent);
         cin1 = 1'b0;
         sub1 = 1'b0;
         @(negedge clk);
         if (c >= 6 && c <= 9) check("stall_in_ready", longint'(ir1), 0);
         if (iv1 && ir1) begin
            q1.push_back(mk(64'(2 * sent), 1'b0, 1'b0));
            sent++;
         end
         @(posedge clk);
         #1;
      end
      iv1 = 1'b0;
      check("stall_sent", sent, 8);
      drain1();

      // Reset with three beats in flight
      or1 = 1'b1;
      for (int i = 0; i < 3; i++) issue1(32'(i + 1), 32'd100, 1'b0, 1'b0, mk(64'(i + 101), 1'b0, 1'b0));
      rst_n = 1'b0;
      q1.delete();
      #1;
      check("midrst_out_valid", longint'(ov1), 0);
      check("midrst_sum", longint'(sum1), 0);
      check("midrst_cout", longint'(cout1), 0);
      check("midrst_ovf", longint'(ovf1), 0);
      check("midrst_in_ready", longint'(ir1), 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      n_ov = 0;
      repeat (10) begin
         @(negedge clk);
         if (ov1) n_ov++;
      end
      check("midrst_no_output", n_ov, 0);
      @(posedge clk);
      #1;
      pop_cyc.delete();
      issue1(32'd0, 32'd0, 1'b1, 1'b0, mk(64'd1, 1'b0, 1'b0));
      drain1();
      check("midrst_latency", lat(), S1);

      // Random traffic, 32/4
      sent = 0;
      n    = 0;
      while ((sent < 300 || q1.size() > 0) && n < 8000) begin
         iv1 = (sent < 300) && ($urandom_range(0, 3) != 0);
         or1 = ($urandom_range(0, 3) != 0);
         ta  = rnd(W1);
         tb  = rnd(W1);
         a1  = ta[W1-1:0];
         b1  = tb[W1-1:0];
         cin1 = 1'($urandom_range(0, 1));
         sub1 = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (iv1 && ir1) begin
            q1.push_back(model(W1, 64'(a1), 64'(b1), cin1, sub1));
            sent++;
         end
         @(posedge clk);
         #1;
         n++;
      end
      iv1 = 1'b0;
      or1 = 1'b1;
      check("rand32_sent", sent, 300);
      check("rand32_drain", longint'(q1.size()), 0);

      // Random traffic, 16/2, 1000 beats
      sent = 0;
      n    = 0;
      while ((sent < 1000 || q2.size() > 0) && n < 20000) begin
         iv2 = (sent < 1000) && ($urandom_range(0, 3) != 0);
         or2 = ($urandom_range(0, 3) != 0);
         ta  = rnd(W2);
         tb  = rnd(W2);
         a2  = ta[W2-1:0];
         b2  = tb[W2-1:0];
         cin2 = 1'($urandom_range(0, 1));
         sub2 = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (iv2 && ir2) begin
            q2.push_back(model(W2, 64'(a2), 64'(b2), cin2, sub2));
            sent++;
         end
         @(posedge clk);
         #1;
         n++;
      end
      iv2 = 1'b0;
      or2 = 1'b1;
      check("rand16_sent", sent, 1000);
      check("rand16_drain", longint'(q2.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
